// File: rtl/aes_key_expansion_pkg.sv
// AES helpers shared by the key schedule and the encryption stage:
// S-box, xtime, round constants and the key-length to round-count mapping.
package aes_key_expansion_pkg;

  localparam int NB = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {ST_IDLE, ST_EXPAND} kx_state_t;

  // Entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nk_to_nr(input int nk);
    case (nk)
      4:       return 10;
      6:       return 12;
      8:       return 14;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_key_expansion_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_expansion.sv
// Sequential AES key schedule: one expanded word per clock, TOTAL-nk cycles after start.
// No backpressure; start is ignored while busy and w_out is held until the next start.
module aes_key_expansion
  import aes_key_expansion_pkg::*;
#(
  parameter int nk = 8,
  parameter int nb = 4,
  parameter int nr = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [32*nk-1:0]          key_in,
  output logic                      busy,
  output logic                      done,
  output logic                      w_valid,
  output logic [32*nb*(nr+1)-1:0]   w_out
);

  localparam int TOTAL = nb * (nr + 1);

  if (!(nk == 4 || nk == 6 || nk == 8)) begin : g_bad_nk
    $error("aes_key_expansion: nk must be 4, 6 or 8");
  end
  if (nb != NB || nr != nk_to_nr(nk)) begin : g_bad_geometry
    $error("aes_key_expansion: nb/nr inconsistent with nk");
  end

  kx_state_t   state_q, state_d;
  logic [5:0]  idx;
  logic [2:0]  kpos;      // idx mod nk, tracked incrementally to avoid a divider
  logic [7:0]  rcon;
  logic        load, wr_en, last;

  logic [31:0] w_arr [TOTAL];
  logic [31:0] prev_w, back_w, rot_w, sub_in, sub_out, temp, new_word;
  logic [5:0]  prev_idx, back_idx;

  assign prev_idx = idx - 6'd1;
  assign back_idx = idx - 6'(nk);
  assign prev_w   = w_arr[prev_idx];
  assign back_w   = w_arr[back_idx];
  assign rot_w    = {prev_w[23:0], prev_w[31:24]};
  assign sub_in   = (kpos == 3'd0) ? rot_w : prev_w;

  aes_sub_word u_sub_word (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    temp = prev_w;
    if (kpos == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 8 && kpos == 3'd4)
      temp = sub_out;
  end

  assign new_word = back_w ^ temp;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    wr_en   = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        wr_en = 1'b1;
        if (idx == 6'(TOTAL - 1)) begin
          last    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx     <= 6'd0;
      kpos    <= 3'd0;
      rcon    <= RCON_INIT;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= last;
      if (load) begin
        idx     <= 6'(nk);
        kpos    <= 3'd0;
        rcon    <= RCON_INIT;
        busy    <= 1'b1;
        w_valid <= 1'b0;
      end else if (wr_en) begin
        idx  <= idx + 6'd1;
        kpos <= (kpos == 3'(nk - 1)) ? 3'd0 : kpos + 3'd1;
        if (kpos == 3'd0)
          rcon <= xtime(rcon);
        if (last) begin
          busy    <= 1'b0;
          w_valid <= 1'b1;
        end
      end
    end
  end

  // Words below nk come straight from the key; the rest are written once each by the expansion.
  for (genvar i = 0; i < TOTAL; i++) begin : g_word
    logic [31:0] q;
    if (i < nk) begin : g_key
      always_ff @(posedge clk) begin
        if (!rst_n)
          q <= '0;
        else if (load)
          q <= key_in[32*(nk-1-i) +: 32];
      end
    end else begin : g_exp
      always_ff @(posedge clk) begin
        if (!rst_n)
          q <= '0;
        else if (wr_en && idx == 6'(i))
          q <= new_word;
      end
    end
    assign w_arr[i]          = q;
    assign w_out[32*i +: 32] = q;
  end

endmodule
